// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS data-memory responder.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;

    // Bit positions inside the error-cause vector.
    localparam int MISALIGN = 0;
    localparam int RANGE    = 1;
    localparam int CONFLICT = 2;
    localparam int ERR_W    = 3;

    typedef logic [ERR_W-1:0] err_cause_t;

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous write, asynchronous read, no reset (contents persist).
// Zero-latency read; no backpressure.
module dmem_array #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 32,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mips_dmem_responder.sv
// Data-memory responder: accepts a read/write, waits WAIT_CYCLES, then strobes ready/err.
// Latency WAIT_CYCLES+1 from accept; stall holds the requester until the response cycle.
module mips_dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              err,
    output logic              stall
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-3:0] IDX_LIM = (ADDR_W-2)'(DEPTH);

    generate
        if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
            $error("WAIT_CYCLES must be within 0..15");
        end
    endgenerate

    state_t            state, next_state;
    logic [3:0]        counter;
    logic [IDX_W-1:0]  cap_idx;
    logic [DATA_W-1:0] cap_wdata;
    logic              cap_wr;
    err_cause_t        cap_cause;

    logic              req;
    logic              accept;
    logic              enter_resp;
    err_cause_t        live_cause;
    logic [IDX_W-1:0]  acc_idx;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_wr;
    err_cause_t        acc_cause;
    logic              arr_we;
    logic [DATA_W-1:0] arr_rdata;

    assign req = mem_read | mem_write;

    always_comb begin
        live_cause           = '0;
        live_cause[MISALIGN] = |addr[1:0];
        live_cause[RANGE]    = addr[ADDR_W-1:2] >= IDX_LIM;
        live_cause[CONFLICT] = mem_read & mem_write;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept     = 1'b1;
                    next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT:    if (counter == 4'd1) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // With zero wait states the response edge is also the accept edge, so the
    // live inputs must feed storage directly instead of the capture registers.
    assign acc_idx    = (state == IDLE) ? addr[IDX_W+1:2] : cap_idx;
    assign acc_wdata  = (state == IDLE) ? wdata           : cap_wdata;
    assign acc_wr     = (state == IDLE) ? mem_write       : cap_wr;
    assign acc_cause  = (state == IDLE) ? live_cause      : cap_cause;

    assign enter_resp = (next_state == RESP) && (state != RESP);
    assign arr_we     = enter_resp & acc_wr & ~(|acc_cause);
    assign stall      = ((state == IDLE) & req) | (state == WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            counter   <= 4'd0;
            cap_idx   <= '0;
            cap_wdata <= '0;
            cap_wr    <= 1'b0;
            cap_cause <= '0;
            rdata     <= '0;
            ready     <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                counter   <= 4'(WAIT_CYCLES);
                cap_idx   <= addr[IDX_W+1:2];
                cap_wdata <= wdata;
                cap_wr    <= mem_write;
                cap_cause <= live_cause;
            end else if (state == WAIT) begin
                counter <= counter - 4'd1;
            end
            ready <= enter_resp;
            err   <= enter_resp & (|acc_cause);
            if (enter_resp) begin
                rdata <= (|acc_cause) ? '0 : arr_rdata;
            end
        end
    end

    dmem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (acc_idx),
        .wdata (acc_wdata),
        .raddr (acc_idx),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Directed bench: instance 0 uses two wait states, instance 1 uses none.
module tb_mips_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd    [2];
    logic        wr    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        ready [2];
    logic        err   [2];
    logic        stall [2];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    mips_dmem_responder #(.WAIT_CYCLES(2)) u_dut2 (
        .clk(clk), .rst(rst), .mem_read(rd[0]), .mem_write(wr[0]),
        .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]),
        .ready(ready[0]), .err(err[0]), .stall(stall[0])
    );

    mips_dmem_responder #(.WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .mem_read(rd[1]), .mem_write(wr[1]),
        .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]),
        .ready(ready[1]), .err(err[1]), .stall(stall[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request on instance s and hold it until ready; lat counts
    // edges from accept to the ready cycle, -1 on timeout.
    task automatic access(input int s, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d, input bit scr,
                          output logic [31:0] q, output logic e,
                          output int lat, output int nst, output time t);
        rd[s] = r; wr[s] = w; addr[s] = a; wdata[s] = d;
        q = '0; e = 1'b0; lat = -1; nst = 0; t = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (stall[s]) nst++;
            if (ready[s]) begin
                q = rdata[s]; e = err[s]; lat = k - 1; t = $time;
                break;
            end
            if (scr && k >= 2) begin
                addr[s]  = 32'h0000_0040;
                wdata[s] = 32'h5555_5555;
            end
        end
        rd[s] = 1'b0; wr[s] = 1'b0;
        @(posedge clk); #1;
    endtask

    logic [31:0] q;
    logic        e;
    int          lat, nst;
    time         t1, t2;

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
        end
        #12;
        chk("rst_ready", 32'(ready[0]), 32'd0);
        chk("rst_err",   32'(err[0]),   32'd0);
        chk("rst_rdata", rdata[0],      32'd0);
        chk("rst_stall_idle", 32'(stall[0]), 32'd0);
        rd[0] = 1'b1; #1;
        chk("rst_stall_req", 32'(stall[0]), 32'd1);
        rd[0] = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;

        // Two wait states: write then read back.
        access(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, q, e, lat, nst, t1);
        chk("w2_wr_lat", 32'(lat), 32'd3);
        chk("w2_wr_stall", 32'(nst), 32'd3);
        chk("w2_wr_err", 32'(e), 32'd0);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, q, e, lat, nst, t1);
        chk("w2_rd_lat", 32'(lat), 32'd3);
        chk("w2_rd_stall", 32'(nst), 32'd3);
        chk("w2_rd_data", q, 32'hDEAD_BEEF);
        chk("w2_rd_err", 32'(e), 32'd0);

        // Zero wait states, back to back.
        access(1, 1'b0, 1'b1, 32'h4, 32'h1, 1'b0, q, e, lat, nst, t1);
        chk("w0_wr_lat", 32'(lat), 32'd1);
        chk("w0_wr_stall", 32'(nst), 32'd1);
        access(1, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, q, e, lat, nst, t2);
        chk("w0_rd_lat", 32'(lat), 32'd1);
        chk("w0_rd_data", q, 32'h0000_0001);
        chk("w0_b2b_gap", 32'(t2 - t1), 32'd20);

        // Misaligned write leaves the neighbouring word alone.
        access(1, 1'b0, 1'b1, 32'h6, 32'hFFFF_FFFF, 1'b0, q, e, lat, nst, t1);
        chk("misal_err", 32'(e), 32'd1);
        chk("misal_rdata", q, 32'd0);
        access(1, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, q, e, lat, nst, t1);
        chk("misal_keep", q, 32'h0000_0001);
        chk("misal_keep_err", 32'(e), 32'd0);

        // Out-of-range read and read/write conflict.
        access(0, 1'b1, 1'b0, 32'h1000, 32'h0, 1'b0, q, e, lat, nst, t1);
        chk("oor_err", 32'(e), 32'd1);
        chk("oor_rdata", q, 32'd0);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, q, e, lat, nst, t1);
        chk("pre_conf_rd", q, 32'hDEAD_BEEF);
        access(0, 1'b1, 1'b1, 32'h10, 32'h1234_5678, 1'b0, q, e, lat, nst, t1);
        chk("conf_err", 32'(e), 32'd1);
        chk("conf_rdata", q, 32'd0);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, q, e, lat, nst, t1);
        chk("conf_nowrite", q, 32'hDEAD_BEEF);

        // Reset during WAIT drops the pending write.
        access(0, 1'b0, 1'b1, 32'h20, 32'h1111_1111, 1'b0, q, e, lat, nst, t1);
        chk("pre_rst_wr_err", 32'(e), 32'd0);
        wr[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'hCAFE_F00D;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_state", 32'(u_dut2.state), 32'd1);
        rst = 1'b1; #1;
        chk("mid_rst_state", 32'(u_dut2.state), 32'd0);
        chk("mid_rst_ready", 32'(ready[0]), 32'd0);
        chk("mid_rst_err",   32'(err[0]),   32'd0);
        chk("mid_rst_rdata", rdata[0],      32'd0);
        chk("mid_rst_stall", 32'(stall[0]), 32'd1);
        wr[0] = 1'b0; #1;
        chk("mid_rst_stall_lo", 32'(stall[0]), 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
        access(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, q, e, lat, nst, t1);
        chk("post_rst_rd", q, 32'h1111_1111);

        // Inputs changed during WAIT must not disturb the captured access.
        access(0, 1'b0, 1'b1, 32'h40, 32'h4040_4040, 1'b0, q, e, lat, nst, t1);
        access(0, 1'b0, 1'b1, 32'h30, 32'h3030_3030, 1'b1, q, e, lat, nst, t1);
        chk("scr_lat", 32'(lat), 32'd3);
        chk("scr_err", 32'(e), 32'd0);
        access(0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, q, e, lat, nst, t1);
        chk("scr_rd_target", q, 32'h3030_3030);
        access(0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, q, e, lat, nst, t1);
        chk("scr_rd_other", q, 32'h4040_4040);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
